// File: rtl/spi_master.sv
// SPI mode-0 master, MSB first, single slave select.
// Sends one full-duplex N-bit frame per accepted start. sclk is derived from clk
// by a down-counter that holds each sclk half-period for CLK_DIV cycles.
//
// state | meaning
// IDLE  | ssbar high, waiting for start
// LEAD  | ssbar low, first bit on mosi, sclk low for one half-period
// HIGH  | sclk high; miso captured on entry
// LOW   | sclk low between bits; next bit already on mosi
// TRAIL | sclk low, ssbar still low, for one half-period after the last bit
// DONE  | single cycle with done high; returns to IDLE
module spi_master #(
  parameter int N       = 8,
  parameter int CLK_DIV = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] din,
  output logic [N-1:0] dout,
  output logic         busy,
  output logic         done,
  output logic         sclk,
  output logic         mosi,
  input  logic         miso,
  output logic         ssbar
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] H_LOAD    = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BITS_LOAD = BW'(N - 1);

  typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, TRAIL, DONE} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] bits, bits_n;
  logic [N-1:0]  tx, tx_n;
  logic [N-1:0]  rx, rx_n;
  logic [N-1:0]  dout_n;
  logic          busy_n, done_n, sclk_n, mosi_n, ssbar_n;

  // State, timer, shift registers and registered pin outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      bits  <= '0;
      tx    <= '0;
      rx    <= '0;
      dout  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sclk  <= 1'b0;
      mosi  <= 1'b0;
      ssbar <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      bits  <= bits_n;
      tx    <= tx_n;
      rx    <= rx_n;
      dout  <= dout_n;
      busy  <= busy_n;
      done  <= done_n;
      sclk  <= sclk_n;
      mosi  <= mosi_n;
      ssbar <= ssbar_n;
    end
  end

  // Next-state and next-output decode; the half-period timer counts down to zero.
  always_comb begin
    state_n = state;
    cnt_n   = (cnt != '0) ? cnt - 1'b1 : cnt;
    bits_n  = bits;
    tx_n    = tx;
    rx_n    = rx;
    dout_n  = dout;
    busy_n  = busy;
    done_n  = done;
    sclk_n  = sclk;
    mosi_n  = mosi;
    ssbar_n = ssbar;
    case (state)
      IDLE: begin
        if (start) begin
          tx_n    = din;
          mosi_n  = din[N-1];
          ssbar_n = 1'b0;
          busy_n  = 1'b1;
          bits_n  = BITS_LOAD;
          cnt_n   = H_LOAD;
          state_n = LEAD;
        end
      end
      LEAD, LOW: begin
        if (cnt == '0) begin
          sclk_n  = 1'b1;
          rx_n    = {rx[N-2:0], miso};
          cnt_n   = H_LOAD;
          state_n = HIGH;
        end
      end
      HIGH: begin
        if (cnt == '0) begin
          sclk_n = 1'b0;
          cnt_n  = H_LOAD;
          if (bits == '0) begin
            state_n = TRAIL;
          end else begin
            tx_n    = {tx[N-2:0], 1'b0};
            mosi_n  = tx[N-2];
            bits_n  = bits - 1'b1;
            state_n = LOW;
          end
        end
      end
      TRAIL: begin
        if (cnt == '0) begin
          ssbar_n = 1'b1;
          mosi_n  = 1'b0;
          dout_n  = rx;
          done_n  = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        done_n  = 1'b0;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: a behavioural slave model answers each frame,
// expected words are queued at stimulus time and checked when done pulses.
module tb_spi_master;

  typedef struct {
    logic [7:0] m;   // word the master must return on dout
    logic [7:0] s;   // word the slave must have received on mosi
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       busy, done, sclk, mosi, miso, ssbar;
  logic       loop = 1'b1;

  logic       start1 = 1'b0;
  logic [7:0] din1 = 8'h00;
  logic [7:0] dout1;
  logic       busy1, done1, sclk1, mosi1, ssbar1;

  int total = 0;
  int bad = 0;

  spi_master #(.N(8), .CLK_DIV(2)) dut (
    .clk(clk), .rst(rst), .start(start), .din(din), .dout(dout), .busy(busy),
    .done(done), .sclk(sclk), .mosi(mosi), .miso(miso), .ssbar(ssbar)
  );

  spi_master #(.N(8), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .din(din1), .dout(dout1), .busy(busy1),
    .done(done1), .sclk(sclk1), .mosi(mosi1), .miso(mosi1), .ssbar(ssbar1)
  );

  task automatic chk(input bit ok, input string name, input int act, input int req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Behavioural mode-0 slave: loads its word when selected, shifts on falling sclk.
  logic [7:0] sl_word = 8'h00;
  logic [7:0] sl_tx = 8'h00;
  logic [7:0] sl_rx = 8'h00;
  logic       sl_miso = 1'b0;
  logic [7:0] exp_tx = 8'h00;
  int         rise_cnt = 0;

  assign miso = loop ? mosi : sl_miso;

  always @(negedge ssbar) begin
    sl_tx    = sl_word;
    sl_miso  = sl_word[7];
    sl_rx    = 8'h00;
    rise_cnt = 0;
  end

  always @(posedge sclk) begin
    if (!ssbar && !rst) begin
      sl_rx = {sl_rx[6:0], mosi};
      if (rise_cnt < 8) chk(mosi == exp_tx[7-rise_cnt], "mosi_bit", mosi, exp_tx[7-rise_cnt]);
      rise_cnt++;
    end
  end

  always @(negedge sclk) begin
    if (!ssbar) begin
      sl_tx   = {sl_tx[6:0], 1'b0};
      sl_miso = sl_tx[7];
    end
  end

  // Monitor for the CLK_DIV=2 instance: protocol rules and scoreboard pop on done.
  exp_t q[$];
  int   low_cnt = 0;
  int   done_cnt = 0;
  int   frames = 0;
  logic prev_sclk = 1'b0, prev_ssbar = 1'b1, prev_mosi = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (ssbar !== prev_ssbar)
        chk(!sclk && !prev_sclk, "sclk_at_ssbar_edge", sclk, 0);
      if (prev_ssbar && !ssbar) frames++;
      if (sclk && !prev_sclk)
        chk(mosi == prev_mosi, "mosi_stable_at_rise", mosi, prev_mosi);
      if (done) begin
        done_cnt++;
        if (q.size() == 0) begin
          chk(1'b0, "unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk(dout == e.m, "master_dout", dout, e.m);
          chk(sl_rx == e.s, "slave_rx", sl_rx, e.s);
          chk(low_cnt == 34, "ssbar_low_cycles", low_cnt, 34);
          chk(rise_cnt == 8, "sclk_rises", rise_cnt, 8);
          chk(busy == 1'b1, "busy_in_done", busy, 1);
        end
      end
    end
    low_cnt    = ssbar ? 0 : low_cnt + 1;
    prev_sclk  = sclk;
    prev_ssbar = ssbar;
    prev_mosi  = mosi;
  end

  // Monitor for the CLK_DIV=1 loopback instance.
  logic [7:0] q1[$];
  int   low1 = 0, hi1 = 0, done1_cnt = 0, frames1 = 0;
  logic prev_ssbar1 = 1'b1;

  always @(negedge clk) begin
    logic [7:0] e1;
    if (!rst) begin
      if (prev_ssbar1 && !ssbar1) begin
        if (frames1 > 0) chk(hi1 >= 1, "ssbar_gap", hi1, 1);
        frames1++;
      end
      if (done1) begin
        done1_cnt++;
        if (q1.size() == 0) begin
          chk(1'b0, "unexpected_done1", 1, 0);
        end else begin
          e1 = q1.pop_front();
          chk(dout1 == e1, "dout_div1", dout1, e1);
          chk(low1 == 17, "ssbar_low_div1", low1, 17);
        end
      end
    end
    low1        = ssbar1 ? 0 : low1 + 1;
    hi1         = ssbar1 ? hi1 + 1 : 0;
    prev_ssbar1 = ssbar1;
  end

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk(1'b0, name, 1, 0);
  endtask

  task automatic send(input logic [7:0] d, input logic [7:0] sw, input bit lp);
    exp_t e;
    wait_idle("idle_timeout_pre");
    loop    = lp;
    sl_word = sw;
    din     = d;
    exp_tx  = d;
    start   = 1'b1;
    e.m = lp ? d : sw;
    e.s = d;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    din   = 8'($urandom);
    wait_idle("frame_timeout");
  endtask

  initial begin
    int n;
    int fr;
    int dc;
    exp_t e;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk(sclk == 0, "rst_sclk", sclk, 0);
    chk(ssbar == 1, "rst_ssbar", ssbar, 1);
    chk(mosi == 0, "rst_mosi", mosi, 0);
    chk(busy == 0, "rst_busy", busy, 0);
    chk(done == 0, "rst_done", done, 0);
    chk(dout == 0, "rst_dout", dout, 0);

    // CLK_DIV=1, start held high: two back-to-back loopback frames.
    q1.push_back(8'hA5);
    q1.push_back(8'h3C);
    din1   = 8'hA5;
    start1 = 1'b1;
    @(negedge clk);
    din1 = 8'h3C;
    n = 0;
    while (done1_cnt < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    start1 = 1'b0;
    chk(done1_cnt == 2, "div1_frames_done", done1_cnt, 2);
    repeat (10) @(negedge clk);
    chk(frames1 == 2, "div1_frame_count", frames1, 2);

    // Directed frames: loopback, slave exchanges, A5 pattern.
    send(8'h12, 8'h00, 1'b1);
    send(8'h12, 8'h01, 1'b0);
    send(8'd55, 8'd20, 1'b0);
    send(8'hA5, 8'h5A, 1'b0);

    // start while busy (at E0+10 and in the done cycle) must be ignored.
    wait_idle("idle_timeout_busy");
    loop    = 1'b0;
    sl_word = 8'h99;
    din     = 8'h3C;
    exp_tx  = 8'h3C;
    start   = 1'b1;
    e.m = 8'h99;
    e.s = 8'h3C;
    q.push_back(e);
    fr = frames;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    din   = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(done == 1, "done_seen", done, 1);
    din   = 8'h77;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    chk(frames == fr + 1, "busy_start_ignored", frames - fr, 1);
    chk(dout == 8'h99, "dout_first_word_only", dout, 8'h99);

    // Randomized frames with random idle gaps.
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    end
    chk(q.size() == 0, "queue_drained", q.size(), 0);

    // Reset mid-frame: outputs cleared, no done afterwards, dout cleared.
    wait_idle("idle_timeout_rst");
    loop    = 1'b0;
    sl_word = 8'hC3;
    din     = 8'h81;
    exp_tx  = 8'h81;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk(sclk == 0, "midrst_sclk", sclk, 0);
    chk(ssbar == 1, "midrst_ssbar", ssbar, 1);
    chk(mosi == 0, "midrst_mosi", mosi, 0);
    chk(busy == 0, "midrst_busy", busy, 0);
    chk(done == 0, "midrst_done", done, 0);
    chk(dout == 0, "midrst_dout", dout, 0);
    rst = 1'b0;
    dc = done_cnt;
    repeat (60) @(negedge clk);
    chk(done_cnt == dc, "no_done_after_rst", done_cnt - dc, 0);
    chk(dout == 0, "dout_held_zero", dout, 0);

    send(8'h6E, 8'hB1, 1'b0);
    chk(dout == 8'hB1, "post_rst_frame", dout, 8'hB1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
